// File: rtl/dump_seq_if.sv
// dump_seq_if: bundle between the capture-dump sequencer and its surroundings
// (command decoder, address counter, SPI master, UART transmitter, RAM mux).
//
//   master modport : the sequencer (dump_seq)
//   slave modport  : the environment driving commands and handshake levels
//
// Handshake rules:
//   spi_rdy / uart_rdy are levels meaning "engine idle". start_spi or
//   start_uart is a one-cycle pulse issued only in a cycle where the matching
//   rdy is high; the engine drops rdy after accepting and raises it again when
//   the transaction completes. start_dump and abort are one-cycle requests
//   with no back-pressure: start_dump is ignored unless the sequencer is idle,
//   and abort is ignored when idle or already draining.
//
// Signals:
//   start_dump, abort, channel, dump_len, stride   command inputs
//   afe_gain                                       packed per-channel gain codes
//   addr                                           RAM read address (counter)
//   spi_rdy, uart_rdy                              engine idle levels
//   start_spi, spi_tx_data, flop_gain, flop_offset SPI side outputs
//   inc_addr, ch_sel                               RAM side outputs
//   start_uart, busy, dump_done, err_chan          host side outputs
//   state_dbg                                      raw sequencer state code
interface dump_seq_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int GAIN_W = 3
);
  logic                       start_dump;
  logic                       abort;
  logic [1:0]                 channel;
  logic [ADDR_W:0]            dump_len;
  logic [ADDR_W-1:0]          stride;
  logic [NUM_CH*GAIN_W-1:0]   afe_gain;
  logic [ADDR_W-1:0]          addr;
  logic                       spi_rdy;
  logic                       uart_rdy;
  logic                       start_spi;
  logic [15:0]                spi_tx_data;
  logic                       flop_gain;
  logic                       flop_offset;
  logic                       inc_addr;
  logic [1:0]                 ch_sel;
  logic                       start_uart;
  logic                       busy;
  logic                       dump_done;
  logic                       err_chan;
  logic [3:0]                 state_dbg;

  modport master (
    input  start_dump, abort, channel, dump_len, stride, afe_gain, addr,
           spi_rdy, uart_rdy,
    output start_spi, spi_tx_data, flop_gain, flop_offset, inc_addr, ch_sel,
           start_uart, busy, dump_done, err_chan, state_dbg
  );

  modport slave (
    output start_dump, abort, channel, dump_len, stride, afe_gain, addr,
           spi_rdy, uart_rdy,
    input  start_spi, spi_tx_data, flop_gain, flop_offset, inc_addr, ch_sel,
           start_uart, busy, dump_done, err_chan, state_dbg
  );
endinterface

// File: rtl/dump_seq.sv
// dump_seq: capture-dump sequencer. On an accepted dump command it reads the
// selected channel's gain and offset calibration words from the EEPROM over
// SPI, then streams samples from the circular capture RAM to the UART, one
// response per sample, stepping the address counter by the latched stride.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    dump_seq_if.master (commands, handshakes, SPI/UART/RAM controls,
//          state_dbg exposing the raw state code)
module dump_seq #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 9,
  parameter int GAIN_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  dump_seq_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_GAIN, S_RD_OFF, S_RD_JUNK, S_EE_WAIT,
    S_U_SEND, S_ADV, S_CHECK, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [1:0]         ch_sel_q;
  logic [ADDR_W-1:0]  start_addr;
  logic [ADDR_W-1:0]  stride_reg;
  logic [ADDR_W-1:0]  stride_cnt;
  logic [ADDR_W:0]    len_reg;
  logic [ADDR_W:0]    sample_cnt;

  logic               chan_ok;
  logic               run;
  logic               accept;
  logic               cmd_bit;
  logic [GAIN_W-1:0]  gain_raw;
  logic [GAIN_W+2:0]  gain_ext;
  logic [2:0]         ggg;

  logic               start_spi_c, flop_gain_c, flop_offset_c, inc_addr_c;
  logic               start_uart_c, dump_done_c, err_chan_c;
  logic [15:0]        spi_tx_c;

  assign chan_ok  = (32'(bus.channel) < NUM_CH);
  // Abort wins over every action in the active states; IDLE and DONE ignore it.
  assign run      = !(bus.abort && (state != S_IDLE) && (state != S_DONE));
  assign gain_raw = bus.afe_gain[32'(ch_sel_q)*GAIN_W +: GAIN_W];
  // Zero-extend then take 3 bits: covers both narrower and wider gain codes.
  assign gain_ext = {3'b000, gain_raw};
  assign ggg      = gain_ext[2:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_IDLE:    if (bus.start_dump && chan_ok) state_nxt = S_RD_GAIN;
        S_RD_GAIN: if (bus.spi_rdy)               state_nxt = S_RD_OFF;
        S_RD_OFF:  if (bus.spi_rdy)               state_nxt = S_RD_JUNK;
        S_RD_JUNK: if (bus.spi_rdy)               state_nxt = S_EE_WAIT;
        S_EE_WAIT: if (bus.spi_rdy)               state_nxt = S_U_SEND;
        S_U_SEND:  if (bus.uart_rdy)              state_nxt = S_ADV;
        S_ADV:     if (stride_cnt == ADDR_W'(1))  state_nxt = S_CHECK;
        // addr == start_addr stops a dump that has walked all the way round.
        S_CHECK:   if (sample_cnt == len_reg || bus.addr == start_addr)
                     state_nxt = S_DONE;
                   else
                     state_nxt = S_U_SEND;
        S_DONE:    if (bus.uart_rdy)              state_nxt = S_IDLE;
        default:                                  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    start_spi_c   = 1'b0;
    flop_gain_c   = 1'b0;
    flop_offset_c = 1'b0;
    inc_addr_c    = 1'b0;
    start_uart_c  = 1'b0;
    dump_done_c   = 1'b0;
    err_chan_c    = 1'b0;
    accept        = 1'b0;
    cmd_bit       = 1'b0;
    case (state)
      S_IDLE: begin
        accept = bus.start_dump && chan_ok;
        if (bus.start_dump && !chan_ok) begin
          err_chan_c  = 1'b1;
          dump_done_c = 1'b1;
        end
      end
      S_RD_GAIN: if (run && bus.spi_rdy) begin
        start_spi_c = 1'b1;
        cmd_bit     = 1'b1;
      end
      S_RD_OFF:  if (run && bus.spi_rdy) start_spi_c = 1'b1;
      // The junk read clocks the offset word out; its start marks the gain
      // word as received.
      S_RD_JUNK: if (run && bus.spi_rdy) begin
        start_spi_c = 1'b1;
        flop_gain_c = 1'b1;
      end
      S_EE_WAIT: if (run && bus.spi_rdy) flop_offset_c = 1'b1;
      S_U_SEND:  if (run && bus.uart_rdy) start_uart_c = 1'b1;
      S_ADV:     if (run) inc_addr_c = 1'b1;
      S_DONE:    if (bus.uart_rdy) dump_done_c = 1'b1;
      default: ;
    endcase
    spi_tx_c = start_spi_c ? {2'b00, ch_sel_q, ggg, cmd_bit, 8'h00} : 16'h0000;
  end

  // Dump parameters and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel_q   <= 2'd0;
      start_addr <= '0;
      len_reg    <= '0;
      stride_reg <= '0;
      stride_cnt <= '0;
      sample_cnt <= '0;
    end else begin
      if (accept) begin
        ch_sel_q   <= bus.channel;
        start_addr <= bus.addr;
        len_reg    <= (bus.dump_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : bus.dump_len;
        stride_reg <= (bus.stride == '0) ? ADDR_W'(1) : bus.stride;
        sample_cnt <= '0;
      end
      if (start_uart_c) begin
        sample_cnt <= sample_cnt + 1'b1;
        stride_cnt <= stride_reg;
      end else if (inc_addr_c) begin
        stride_cnt <= stride_cnt - 1'b1;
      end
    end
  end

  assign bus.start_spi   = start_spi_c;
  assign bus.spi_tx_data = spi_tx_c;
  assign bus.flop_gain   = flop_gain_c;
  assign bus.flop_offset = flop_offset_c;
  assign bus.inc_addr    = inc_addr_c;
  assign bus.ch_sel      = ch_sel_q;
  assign bus.start_uart  = start_uart_c;
  assign bus.busy        = (state != S_IDLE);
  assign bus.dump_done   = dump_done_c;
  assign bus.err_chan    = err_chan_c;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_dump_seq.sv
// tb_dump_seq: bench for dump_seq. An environment process models the address
// counter and SPI/UART engines (rdy drops for a programmable number of cycles
// after each start) and logs every DUT pulse; the main sequence issues dumps
// and compares the logs against a reference computed from the dump rules.
module tb_dump_seq;
  localparam int NUM_CH = 3;
  localparam int ADDR_W = 9;
  localparam int GAIN_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dump_seq_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) bus ();

  dump_seq #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Environment state (written only by the env process, except the knobs)
  logic [ADDR_W-1:0] addr_ctr = '0;
  logic [ADDR_W-1:0] addr_ofs = '0;
  logic spi_rdy_r = 1'b1, uart_rdy_r = 1'b1, uart_hold = 1'b0;
  int spi_stall = 0, uart_stall = 0;
  int spi_n = 0, uart_n = 0, inc_n = 0, fg_n = 0, fo_n = 0;
  int done_n = 0, err_n = 0, err_done_n = 0, viol_n = 0;
  logic [15:0]       spi_log[$];
  logic [ADDR_W-1:0] uart_log[$];

  // Scoreboard
  logic [ADDR_W-1:0] exp_q[$];
  logic [2:0]        gain_arr [NUM_CH];

  assign bus.addr     = addr_ctr + addr_ofs;
  assign bus.spi_rdy  = spi_rdy_r;
  assign bus.uart_rdy = uart_rdy_r & ~uart_hold;

  initial begin : env
    logic inc_seen, spi_go, uart_go;
    int spi_left, uart_left;
    inc_seen = 1'b0; spi_go = 1'b0; uart_go = 1'b0;
    spi_left = 0; uart_left = 0;
    forever begin
      @(negedge clk);
      inc_seen = bus.inc_addr;
      spi_go   = bus.start_spi;
      uart_go  = bus.start_uart;
      if (bus.start_spi) begin
        spi_log.push_back(bus.spi_tx_data);
        spi_n++;
        if (!bus.spi_rdy) viol_n++;
      end
      if (bus.start_uart) begin
        uart_log.push_back(bus.addr);
        uart_n++;
        if (!bus.uart_rdy) viol_n++;
      end
      if (bus.inc_addr)    inc_n++;
      if (bus.flop_gain)   fg_n++;
      if (bus.flop_offset) fo_n++;
      if (bus.dump_done)   done_n++;
      if (bus.err_chan)    err_n++;
      if (bus.err_chan && bus.dump_done) err_done_n++;
      @(posedge clk); #1;
      if (!rst_n) begin
        spi_left = 0; uart_left = 0;
        spi_rdy_r = 1'b1; uart_rdy_r = 1'b1;
      end else begin
        if (inc_seen) addr_ctr = addr_ctr + 1'b1;
        if (spi_go)  spi_left  = spi_stall;
        if (uart_go) uart_left = uart_stall;
        if (spi_left > 0)  begin spi_rdy_r  = 1'b0; spi_left--;  end else spi_rdy_r  = 1'b1;
        if (uart_left > 0) begin uart_rdy_r = 1'b0; uart_left--; end else uart_rdy_r = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: a dump ends after the first sample k that reaches the length,
  // or after which the stepped address is back at the start address.
  function automatic int model_samples(input int len, input int strd);
    int l_eff, s_eff;
    l_eff = (len == 0) ? DEPTH : len;
    s_eff = (strd == 0) ? 1 : strd;
    for (int k = 1; k < DEPTH; k++)
      if (k == l_eff || ((k * s_eff) % DEPTH) == 0) return k;
    return DEPTH;
  endfunction

  function automatic logic [15:0] model_word(input int ch, input logic cmd);
    return {2'b00, 2'(ch), gain_arr[ch], cmd, 8'h00};
  endfunction

  task automatic set_gains();
    for (int c = 0; c < NUM_CH; c++) begin
      gain_arr[c] = 3'($urandom_range(0, 7));
      bus.afe_gain[c*GAIN_W +: GAIN_W] = gain_arr[c];
    end
  endtask

  task automatic kick(input int ch, input int len, input int strd, input int start);
    @(posedge clk); #2;
    addr_ofs       = ADDR_W'(start) - addr_ctr;
    bus.start_dump = 1'b1;
    bus.channel    = 2'(ch);
    bus.dump_len   = (ADDR_W+1)'(len);
    bus.stride     = ADDR_W'(strd);
    @(posedge clk); #2;
    bus.start_dump = 1'b0;
    bus.channel    = 2'($urandom);
    bus.dump_len   = (ADDR_W+1)'($urandom);
    bus.stride     = ADDR_W'($urandom);
  endtask

  task automatic run_dump(input string tag, input int ch, input int len, input int strd,
                          input int start, input int sst, input int ust);
    int n, s_eff, b_spi, b_uart, b_inc, b_fg, b_fo, b_done, b_err, b_viol, cyc;
    logic [ADDR_W-1:0] a;
    s_eff = (strd == 0) ? 1 : strd;
    n = model_samples(len, strd);
    exp_q.delete();
    a = ADDR_W'(start);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(a);
      a = a + ADDR_W'(s_eff);
    end
    spi_stall = sst; uart_stall = ust;
    b_spi = spi_n; b_uart = uart_n; b_inc = inc_n; b_fg = fg_n; b_fo = fo_n;
    b_done = done_n; b_err = err_n; b_viol = viol_n;
    kick(ch, len, strd, start);
    cyc = 0;
    while (done_n == b_done && cyc < 40000) begin @(posedge clk); cyc++; end
    chk({tag, " done_seen"}, 32'(done_n != b_done), 1);
    repeat (2) @(posedge clk); #2;
    chk({tag, " done_cnt"}, done_n - b_done, 1);
    chk({tag, " busy_after"}, 32'(bus.busy), 0);
    chk({tag, " spi_cnt"}, spi_n - b_spi, 3);
    for (int i = 0; i < 3; i++)
      if (b_spi + i < spi_log.size())
        chk({tag, $sformatf(" spi_word%0d", i)}, spi_log[b_spi + i], model_word(ch, i == 0));
    chk({tag, " flop_gain"}, fg_n - b_fg, 1);
    chk({tag, " flop_offset"}, fo_n - b_fo, 1);
    chk({tag, " uart_cnt"}, uart_n - b_uart, n);
    chk({tag, " inc_cnt"}, inc_n - b_inc, n * s_eff);
    chk({tag, " err_cnt"}, err_n - b_err, 0);
    chk({tag, " rdy_violations"}, viol_n - b_viol, 0);
    chk({tag, " final_addr"}, bus.addr, a);
    for (int k = 0; k < n; k++) begin
      logic [ADDR_W-1:0] e;
      e = exp_q.pop_front();
      if (b_uart + k < uart_log.size())
        chk({tag, $sformatf(" sample%0d_addr", k)}, uart_log[b_uart + k], e);
    end
    spi_stall = 0; uart_stall = 0;
  endtask

  initial begin : main
    int sb, b_uart, b_done, b_spi, b_err, b_ed, cyc, ch;
    rst_n = 1'b0;
    bus.start_dump = 1'b0; bus.abort = 1'b0; bus.channel = 2'd0;
    bus.dump_len = '0; bus.stride = '0; bus.afe_gain = '0;
    for (int c = 0; c < NUM_CH; c++) gain_arr[c] = 3'd0;
    #2;
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset ch_sel", 32'(bus.ch_sel), 0);
    chk("reset spi_tx_data", 32'(bus.spi_tx_data), 0);
    chk("reset pulses", {bus.start_spi, bus.flop_gain, bus.flop_offset, bus.inc_addr,
                         bus.start_uart, bus.dump_done, bus.err_chan}, 0);
    repeat (3) @(posedge clk); #3;
    rst_n = 1'b1;

    // Full depth on channel 1, gain 101
    set_gains();
    gain_arr[1] = 3'b101;
    bus.afe_gain[1*GAIN_W +: GAIN_W] = 3'b101;
    sb = spi_log.size();
    run_dump("full", 1, 0, 1, 0, 0, 0);
    if (sb + 2 < spi_log.size()) begin
      chk("full gain_cmd", spi_log[sb], 16'h1B00);
      chk("full off_cmd", spi_log[sb + 1], 16'h1A00);
      chk("full junk_cmd", spi_log[sb + 2], 16'h1A00);
    end

    // Partial length with stride across the wrap
    run_dump("partial", 1, 10, 4, 'h1F8, 0, 0);
    chk("partial wrap_addr", bus.addr, 9'h020);

    // Same dump with SPI and UART stalls
    run_dump("stall", 1, 10, 4, 'h1F8, 20, 7);

    // Wrap guard stops before the requested length
    run_dump("wrap_guard", 0, 10, 256, 'h055, 0, 0);

    // Invalid channel
    @(posedge clk); #2;
    b_spi = spi_n; b_uart = uart_n; b_err = err_n; b_ed = err_done_n;
    bus.start_dump = 1'b1; bus.channel = 2'd3;
    @(negedge clk);
    chk("badch err_chan", 32'(bus.err_chan), 1);
    chk("badch dump_done", 32'(bus.dump_done), 1);
    chk("badch busy", 32'(bus.busy), 0);
    chk("badch start_spi", 32'(bus.start_spi), 0);
    @(posedge clk); #2;
    bus.start_dump = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("badch busy_after", 32'(bus.busy), 0);
    chk("badch spi_cnt", spi_n - b_spi, 0);
    chk("badch uart_cnt", uart_n - b_uart, 0);
    chk("badch err_cnt", err_n - b_err, 1);
    chk("badch err_with_done", err_done_n - b_ed, 1);

    // Abort as uart_rdy rises for sample 5
    set_gains();
    b_uart = uart_n; b_done = done_n;
    kick(0, 20, 2, $urandom_range(0, DEPTH - 1));
    cyc = 0;
    while (uart_n < b_uart + 4 && cyc < 2000) begin @(posedge clk); cyc++; end
    chk("abort reached_sample4", uart_n - b_uart, 4);
    #2 uart_hold = 1'b1;
    repeat (6) @(posedge clk); #2;
    uart_hold = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    chk("abort start_uart_suppressed", 32'(bus.start_uart), 0);
    chk("abort busy", 32'(bus.busy), 1);
    @(posedge clk); #2;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort dump_done", 32'(bus.dump_done), 1);
    repeat (3) @(posedge clk); #2;
    chk("abort uart_total", uart_n - b_uart, 4);
    chk("abort done_cnt", done_n - b_done, 1);
    chk("abort busy_after", 32'(bus.busy), 0);

    // Abort while the UART is still busy: DONE waits for it
    b_uart = uart_n; b_done = done_n;
    kick(2, 30, 1, $urandom_range(0, DEPTH - 1));
    cyc = 0;
    while (uart_n < b_uart + 1 && cyc < 2000) begin @(posedge clk); cyc++; end
    #2 uart_hold = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #2;
    bus.abort = 1'b0;
    repeat (5) @(posedge clk); #2;
    chk("drain no_done_yet", done_n - b_done, 0);
    chk("drain busy", 32'(bus.busy), 1);
    uart_hold = 1'b0;
    @(negedge clk);
    chk("drain dump_done", 32'(bus.dump_done), 1);
    repeat (2) @(posedge clk); #2;
    chk("drain uart_total", uart_n - b_uart, 1);

    // Reset in the middle of ADV
    set_gains();
    kick(2, 0, 1, $urandom_range(0, DEPTH - 1));
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!(bus.inc_addr && inc_n > 5) && cyc < 2000);
    chk("rst_mid in_adv", 32'(bus.inc_addr), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid busy", 32'(bus.busy), 0);
    chk("rst_mid ch_sel", 32'(bus.ch_sel), 0);
    chk("rst_mid spi_tx_data", 32'(bus.spi_tx_data), 0);
    chk("rst_mid pulses", {bus.start_spi, bus.flop_gain, bus.flop_offset, bus.inc_addr,
                           bus.start_uart, bus.dump_done, bus.err_chan}, 0);
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b1;
    run_dump("post_reset", 1, 0, 1, $urandom_range(0, DEPTH - 1), 0, 0);

    // Randomized dumps
    for (int t = 0; t < 6; t++) begin
      set_gains();
      ch = $urandom_range(0, NUM_CH - 1);
      run_dump($sformatf("rand%0d", t), ch, $urandom_range(1, 24), $urandom_range(0, 24),
               $urandom_range(0, DEPTH - 1), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dump_seq.md
Name: dump_seq

Overview:
- Parametrised next-generation capture-dump sequencer for the scope datapath.
- On a dump command it:
  - fetches the selected channel's gain and offset calibration words from the EEPROM over SPI;
  - then streams captured samples from the circular capture RAM to the host UART, one response per sample.
- Generalises the original fixed 3-channel, full-depth dumper with:
  - a configurable channel count and address width;
  - a programmable sample count and address stride;
  - host abort and invalid-channel rejection.

Parameters:
NUM_CH, 3, number of capture channels (1..4; the SPI command holds a 2-bit channel field)
ADDR_W, 9, capture RAM address width; depth = 2**ADDR_W
GAIN_W, 3, width of each AFE gain code

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_dump  in  1  one-cycle dump request from command decoder
abort  in  1  one-cycle host abort request
channel  in  2  requested channel, sampled with start_dump
dump_len  in  ADDR_W+1  samples to send, sampled with start_dump; 0 means full depth
stride  in  ADDR_W  address step per sample, sampled with start_dump; 0 is treated as 1
afe_gain  in  NUM_CH*GAIN_W  packed gain codes; channel n at bits [n*GAIN_W +: GAIN_W]
addr  in  ADDR_W  current RAM read address from the address counter
spi_rdy  in  1  SPI master idle / transaction complete
uart_rdy  in  1  UART transmitter idle
start_spi  out  1  one-cycle SPI transaction start
spi_tx_data  out  16  EEPROM command word
flop_gain  out  1  capture SPI rx data into gain register
flop_offset  out  1  capture SPI rx data into offset register
inc_addr  out  1  one-cycle increment of the address counter by 1
ch_sel  out  2  registered selected channel (RAM output mux)
start_uart  out  1  one-cycle UART response start
busy  out  1  high in every state except IDLE
dump_done  out  1  one-cycle completion pulse
err_chan  out  1  one-cycle pulse when the requested channel >= NUM_CH

Behaviour:
- Reset values:
  - all pulse outputs 0; spi_tx_data = 0;
  - ch_sel = 0, busy = 0;
  - internal start address, sample counter and stride counter = 0; state = IDLE.
- Registered state:
  - ch_sel, start_addr (= addr), len_reg and stride_reg are latched in the cycle start_dump is accepted in IDLE.
  - len_reg = 2**ADDR_W when dump_len = 0.
  - stride_reg = 1 when stride = 0.
- Gain code: ggg = afe_gain slice indexed by ch_sel.
- spi_tx_data = {2'b00, ch_sel, ggg (zero-extended or truncated to 3 bits), cmd_bit, 8'h00}.
  - cmd_bit = 1 for the gain read.
  - cmd_bit = 0 for the offset read and the junk read.
  - spi_tx_data is valid only in the cycle start_spi = 1; otherwise 0.
- State machine:
  - IDLE: start_dump with channel >= NUM_CH -> err_chan = 1 and dump_done = 1 in the same cycle; stay in IDLE. Valid channel -> latch, go to RD_GAIN.
  - RD_GAIN: start_spi with the gain command; go to RD_OFF.
  - RD_OFF: wait for spi_rdy; then start_spi with the offset command; go to RD_JUNK.
  - RD_JUNK: wait for spi_rdy; then flop_gain = 1 and start_spi with the offset command; go to EE_WAIT.
  - EE_WAIT: wait for spi_rdy; then flop_offset = 1; go to U_SEND.
  - U_SEND: wait for uart_rdy; then start_uart = 1, sample counter += 1, stride counter = stride_reg; go to ADV.
  - ADV: inc_addr = 1 each cycle; stride counter -= 1; go to CHECK when it reaches 1 (exactly stride_reg inc_addr pulses).
  - CHECK: go to DONE if sample counter == len_reg, or if addr == start_addr (wrap guard); otherwise go to U_SEND.
  - DONE: wait for uart_rdy (last byte drained); then dump_done = 1; go to IDLE.
- spi_rdy and uart_rdy are level-sensitive. A new start is never issued while the corresponding rdy is low.
- abort:
  - In any state except IDLE and DONE: go to DONE next cycle.
  - Abort takes priority over every transition in the same cycle, including issuing start_spi or start_uart, which are suppressed.
  - An in-flight SPI or UART transaction is allowed to finish; DONE still waits for uart_rdy.
- start_dump while busy is ignored. abort in IDLE is ignored.
- Address counter wrap is owned by the counter; this block compares full ADDR_W bits only.

Test Plan:
- Valid dump, full depth: channel=1, afe_gain ch1=3'b101, dump_len=0, stride=1, rdy always high.
  - spi_tx_data sequence = 16'h1B00, 16'h1A00, 16'h1A00.
  - flop_gain and flop_offset one pulse each.
  - exactly 512 start_uart pulses and 512 inc_addr pulses, then one dump_done.
- Partial length with stride: dump_len=10, stride=4, start addr=0x1F8.
  - 10 start_uart pulses, 40 inc_addr pulses, dump_done.
  - final addr wraps to 0x020.
- Handshake stall: hold spi_rdy low 20 cycles after the gain start, and uart_rdy low 7 cycles per sample.
  - no start_spi or start_uart issued while rdy is low.
  - pulse counts unchanged vs. the no-stall run.
- Invalid channel: channel=3 with NUM_CH=3.
  - err_chan and dump_done pulse together; busy stays 0; no SPI or UART activity.
- Abort: assert abort in the same cycle uart_rdy rises during sample 5.
  - no start_uart that cycle; DONE entered.
  - dump_done after uart_rdy is high; 4 samples sent total.
- Reset mid-dump: deassert rst_n during ADV.
  - all outputs return to 0 asynchronously.
  - a new start_dump afterwards runs a complete correct dump.
